// File: rtl/branch_resolve_bht_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_bht_if
// Description : Fetch-lookup / execute-resolve / redirect bundle for the
//               branch resolution and history table block.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_bht_if #(
    parameter int N = 16
);
    logic [N-1:0]  f_pc;
    logic          f_pred_taken;
    logic          ex_valid;
    logic          ex_is_branch;
    logic [N-1:0]  ex_pc;
    logic          ex_pred_taken;
    logic          cond;
    logic [N-1:0]  ex_target;
    logic [N-1:0]  ex_pc_inc;
    logic          stall;
    logic          redirect;
    logic [N-1:0]  redirect_pc;
    logic          flush;
    logic [15:0]   mispredict_cnt;

    // Pipeline side: supplies lookup and resolve information.
    modport master (
        output f_pc, ex_valid, ex_is_branch, ex_pc, ex_pred_taken, cond,
               ex_target, ex_pc_inc, stall,
        input  f_pred_taken, redirect, redirect_pc, flush, mispredict_cnt
    );

    // Predictor/resolver side.
    modport slave (
        input  f_pc, ex_valid, ex_is_branch, ex_pc, ex_pred_taken, cond,
               ex_target, ex_pc_inc, stall,
        output f_pred_taken, redirect, redirect_pc, flush, mispredict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_bht
// Description : Execute-stage branch resolution with a direct-mapped table of
//               2-bit saturating counters, registered redirect/flush and a
//               saturating misprediction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_bht #(
    parameter int N        = 16,
    parameter int IDX_BITS = 4
) (
    input  wire                   clk,
    input  wire                   rst,
    branch_resolve_bht_if.slave   bus
);
    localparam int          c_DEPTH    = 2 ** IDX_BITS;
    localparam logic [1:0]  c_WEAK_NT  = 2'b01;
    localparam logic [1:0]  c_STRONG_T = 2'b11;
    localparam logic [1:0]  c_STRONG_N = 2'b00;
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    logic [1:0]          r_bht [c_DEPTH];
    logic                r_redirect;
    logic [N-1:0]        r_redirect_pc;
    logic [15:0]         r_mispredict_cnt;

    logic [IDX_BITS-1:0] w_f_idx;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [1:0]          w_ex_entry;
    logic [1:0]          w_ex_entry_next;
    logic                w_resolve;
    logic                w_mispredict;

    // Halfword-aligned PCs: bit 0 never selects an entry.
    assign w_f_idx  = bus.f_pc[IDX_BITS:1];
    assign w_ex_idx = bus.ex_pc[IDX_BITS:1];

    // Table is written at the edge, so the lookup sees the pre-update value.
    assign bus.f_pred_taken = r_bht[w_f_idx][1];

    // The instruction behind a redirect is wrong-path and must be ignored.
    assign w_resolve    = bus.ex_valid & bus.ex_is_branch & ~bus.stall & ~r_redirect;
    assign w_mispredict = w_resolve & (bus.cond != bus.ex_pred_taken);

    assign w_ex_entry = r_bht[w_ex_idx];

    always_comb begin
        w_ex_entry_next = w_ex_entry;
        if (bus.cond) begin
            if (w_ex_entry != c_STRONG_T) begin
                w_ex_entry_next = w_ex_entry + 2'd1;
            end
        end else begin
            if (w_ex_entry != c_STRONG_N) begin
                w_ex_entry_next = w_ex_entry - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bht[i] <= c_WEAK_NT;
            end
        end else if (w_resolve) begin
            r_bht[w_ex_idx] <= w_ex_entry_next;
        end
    end

    // Redirect is a single-cycle pulse; redirect_pc holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= bus.cond ? bus.ex_target : bus.ex_pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mispredict_cnt <= '0;
        end else if (w_mispredict && (r_mispredict_cnt != c_CNT_MAX)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
        end
    end

    assign bus.redirect       = r_redirect;
    assign bus.flush          = r_redirect;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.mispredict_cnt = r_mispredict_cnt;

    // PC bits outside the index field do not affect this block.
    wire w_unused = ^{bus.f_pc[N-1:IDX_BITS+1], bus.f_pc[0],
                      bus.ex_pc[N-1:IDX_BITS+1], bus.ex_pc[0]};

endmodule
`default_nettype wire
